// File: rtl/red_pitaya_asg_sweep_pkg.sv
// Shared ASG sweep encodings: sweep modes and controller states.
// Also reused by the register bank.
package red_pitaya_asg_sweep_pkg;

  typedef enum logic [1:0] {
    ModeSingle   = 2'd0,
    ModeRepeat   = 2'd1,
    ModePingPong = 2'd2,
    ModeRsvd     = 2'd3
  } sweep_mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } sweep_state_e;

  localparam int unsigned DwellW = 32;

endpackage

// File: rtl/red_pitaya_asg_sweep_tmr.sv
// Dwell timer: after load, pulses tick_o every D = max(dwell, 1) cycles until cleared.
module red_pitaya_asg_sweep_tmr
  import red_pitaya_asg_sweep_pkg::*;
(
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DwellW-1:0] dwell_i,
  output logic              tick_o
);

  logic [DwellW-1:0] cnt_q;
  logic [DwellW-1:0] dwell_q;

  // cnt_q == 0 means stopped; otherwise it counts 1..D and wraps on the tick.
  assign tick_o = (cnt_q != '0) && (cnt_q == dwell_q);

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      cnt_q   <= '0;
      dwell_q <= DwellW'(1);
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      dwell_q <= (dwell_i == '0) ? DwellW'(1) : dwell_i;
      cnt_q   <= DwellW'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= tick_o ? DwellW'(1) : cnt_q + DwellW'(1);
    end
  end

endmodule

// File: rtl/red_pitaya_asg_sweep.sv
// Step sweep controller: walks step_o from set_start toward set_stop in single,
// repeat or ping-pong mode, one update per dwell period, clamped at the target.
module red_pitaya_asg_sweep
  import red_pitaya_asg_sweep_pkg::*;
#(
  parameter int unsigned RSZ = 14
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [RSZ+15:0]   set_start_i,
  input  logic [RSZ+15:0]   set_stop_i,
  input  logic [RSZ+15:0]   set_inc_i,
  input  logic [DwellW-1:0] set_dwell_i,
  input  logic [1:0]        set_mode_i,
  output logic [RSZ+15:0]   step_o,
  output logic              step_vld_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dir_o
);

  localparam int unsigned W = RSZ + 16;

  sweep_state_e state_q, state_d;
  sweep_mode_e  mode_q, mode_d;
  logic [W-1:0] start_q, start_d;
  logic [W-1:0] stop_q, stop_d;
  logic [W-1:0] inc_q, inc_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic         dir_q, dir_d;
  logic         vld_q, vld_d;
  logic         done_q, done_d;
  logic         end_q, end_d;
  logic         tmr_load, tmr_clr, tick, arrive;
  logic [W:0]   sum, diff;

  red_pitaya_asg_sweep_tmr u_tmr (
    .dac_clk_i (dac_clk_i),
    .dac_rst_i (dac_rst_i),
    .clr_i     (tmr_clr),
    .load_i    (tmr_load),
    .dwell_i   (set_dwell_i),
    .tick_o    (tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    step_d   = step_q;
    tgt_d    = tgt_q;
    dir_d    = dir_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    end_d    = end_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    // Extra top bit catches overflow/underflow of the step arithmetic.
    sum      = {1'b0, step_q} + {1'b0, inc_q};
    diff     = {1'b0, step_q} - {1'b0, inc_q};

    if (stop_i) begin
      state_d = StIdle;
      tmr_clr = 1'b1;
    end else if (start_i) begin
      state_d  = StRun;
      mode_d   = sweep_mode_e'(set_mode_i);
      start_d  = set_start_i;
      stop_d   = set_stop_i;
      inc_d    = set_inc_i;
      step_d   = set_start_i;
      tgt_d    = set_stop_i;
      dir_d    = (set_stop_i >= set_start_i);
      end_d    = 1'b0;
      vld_d    = 1'b1;
      tmr_load = 1'b1;
    end else if (state_q == StRun) begin
      if (done_q) begin
        state_d = StIdle;
      end else if (tick) begin
        vld_d = 1'b1;
        if (end_q) begin
          step_d = start_q;
          end_d  = 1'b0;
        end else if (dir_q) begin
          step_d = (sum[W] || (sum[W-1:0] >= tgt_q)) ? tgt_q : sum[W-1:0];
        end else begin
          step_d = (diff[W] || (diff[W-1:0] <= tgt_q)) ? tgt_q : diff[W-1:0];
        end
      end
    end

    arrive = vld_d && (step_d == tgt_d);
    if (arrive) begin
      case (mode_d)
        ModeRepeat: end_d = 1'b1;
        ModePingPong: begin
          dir_d = ~dir_d;
          tgt_d = (tgt_d == stop_d) ? start_d : stop_d;
        end
        default: begin
          // Single (and reserved): finish; busy_o drops the cycle after done_o.
          done_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= StIdle;
      mode_q  <= ModeSingle;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      step_q  <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b1;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      step_q  <= step_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      end_q   <= end_d;
    end
  end

  assign step_o     = step_q;
  assign step_vld_o = vld_q;
  assign busy_o     = (state_q == StRun);
  assign done_o     = done_q;
  assign dir_o      = dir_q;

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Bench for red_pitaya_asg_sweep: directed and random sweeps checked cycle by cycle
// against an integer model of the sweep rules.
module tb_red_pitaya_asg_sweep;

  localparam int unsigned RSZ  = 14;
  localparam int unsigned W    = RSZ + 16;
  localparam longint      WMAX = longint'(1) << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [W-1:0]  set_start = '0;
  logic [W-1:0]  set_stop = '0;
  logic [W-1:0]  set_inc = '0;
  logic [31:0]   set_dwell = '0;
  logic [1:0]    set_mode = '0;
  logic [W-1:0]  step_o;
  logic          step_vld_o, busy_o, done_o, dir_o;

  int n_pass = 0;
  int n_fail = 0;

  red_pitaya_asg_sweep #(.RSZ(RSZ)) dut (
    .dac_clk_i   (clk),
    .dac_rst_i   (rst),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .set_start_i (set_start),
    .set_stop_i  (set_stop),
    .set_inc_i   (set_inc),
    .set_dwell_i (set_dwell),
    .set_mode_i  (set_mode),
    .step_o      (step_o),
    .step_vld_o  (step_vld_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dir_o       (dir_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input longint e_step, input bit e_vld,
                               input bit e_busy, input bit e_done, input bit e_dir);
    check({tag, " step"}, 64'(step_o), 64'(e_step));
    check({tag, " vld"}, 64'(step_vld_o), 64'(e_vld));
    check({tag, " busy"}, 64'(busy_o), 64'(e_busy));
    check({tag, " done"}, 64'(done_o), 64'(e_done));
    check({tag, " dir"}, 64'(dir_o), 64'(e_dir));
  endtask

  // Start a sweep and follow it for ncyc cycles. stop_at > 0 pulses stop_i in that
  // cycle; scramble changes every set_* input after the start has been taken.
  task automatic run_sweep(input string name, input longint s, input longint p,
                           input longint inc, input int dwell, input int mode,
                           input int ncyc, input int stop_at, input bit scramble);
    longint val, tgt, nxt;
    bit     dir, pend, vld, dn, arrive, stopped;
    int     d, last, done_c;
    @(negedge clk);
    set_start = s[W-1:0];
    set_stop  = p[W-1:0];
    set_inc   = inc[W-1:0];
    set_dwell = dwell;
    set_mode  = mode[1:0];
    start_i   = 1'b1;
    d = (dwell < 1) ? 1 : dwell;
    val = 0; tgt = p; dir = 1'b1; pend = 1'b0; last = 0; done_c = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      stop_i  = 1'b0;
      if (scramble) begin
        set_start = W'($urandom);
        set_stop  = W'($urandom);
        set_inc   = W'($urandom);
        set_dwell = $urandom_range(0, 5);
        set_mode  = 2'($urandom);
      end
      @(negedge clk);
      stopped = (stop_at > 0) && (c > stop_at);
      vld = 1'b0; dn = 1'b0; arrive = 1'b0;
      if (!stopped && done_c == 0) begin
        if (c == 1) begin
          val = s; tgt = p; dir = (p >= s); vld = 1'b1;
        end else if (c == last + d) begin
          vld = 1'b1;
          if (pend) begin
            val = s; pend = 1'b0;
          end else if (dir) begin
            nxt = val + inc;
            val = (nxt >= tgt || nxt >= WMAX) ? tgt : nxt;
          end else begin
            nxt = val - inc;
            val = (nxt <= tgt) ? tgt : nxt;
          end
        end
        if (vld) begin
          last = c;
          arrive = (val == tgt);
        end
        if (arrive) begin
          if (mode == 1) pend = 1'b1;
          else if (mode == 2) begin
            dir = !dir;
            tgt = (tgt == p) ? s : p;
          end else begin
            dn = 1'b1;
            done_c = c;
          end
        end
      end
      check_outputs($sformatf("%s c%0d", name, c), val, vld,
                    !stopped && (done_c == 0 || c <= done_c), dn, dir);
      if (c == stop_at) stop_i = 1'b1;
    end
    stop_i = 1'b0;
  endtask

  initial begin
    longint s, p, inc;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // start and stop together in idle: stop wins, nothing moves
    @(negedge clk);
    set_start = W'(32'h10000); set_stop = W'(32'h20000); set_inc = W'(32'h1000);
    set_dwell = 1; set_mode = 0;
    start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0; stop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs($sformatf("start+stop idle %0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    run_sweep("single", 64'h10000, 64'h50000, 64'h10000, 3, 0, 18, 0, 1'b1);
    run_sweep("clamp", 64'h0, 64'h25000, 64'h10000, 1, 0, 8, 0, 1'b0);
    run_sweep("pingpong", 64'h30000, 64'h10000, 64'h10000, 1, 2, 14, 0, 1'b0);
    run_sweep("overflow", 64'h3FFF0000, 64'h3FFFFFFF, 64'h20000000, 2, 0, 8, 0, 1'b0);
    run_sweep("stop", 64'h0, 64'h80000, 64'h10000, 2, 0, 14, 5, 1'b0);
    run_sweep("dwell0", 64'h0, 64'h40000, 64'h10000, 0, 3, 8, 0, 1'b0);
    run_sweep("equal", 64'h20000, 64'h20000, 64'h10000, 2, 0, 4, 0, 1'b0);
    run_sweep("inc0", 64'h20000, 64'h30000, 64'h0, 2, 0, 10, 0, 1'b0);
    run_sweep("repeat", 64'h10000, 64'h30000, 64'h10000, 2, 1, 20, 0, 1'b1);
    // restart while busy, then reset mid-sweep with start_i high
    run_sweep("restart", 64'h50000, 64'h10000, 64'h8000, 1, 1, 6, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check_outputs("midreset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("midreset+1", 0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = longint'($urandom) & (WMAX - 1);
        p = longint'($urandom) & (WMAX - 1);
        inc = longint'($urandom) & (WMAX - 1);
      end else begin
        s = longint'($urandom_range(0, 6)) << 16;
        p = longint'($urandom_range(0, 6)) << 16;
        inc = longint'($urandom_range(0, 5)) << 15;
      end
      run_sweep($sformatf("rand%0d", r), s, p, inc, $urandom_range(0, 3),
                $urandom_range(0, 3), 30,
                ($urandom_range(0, 2) == 0) ? $urandom_range(2, 25) : 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_asg_sweep.md
RED_PITAYA_ASG_SWEEP -- requirements
Module: red_pitaya_asg_sweep

Interface
REQ-001 SHALL have parameter RSZ, default 14, buffer address width; step width W = RSZ+16, in 16.16-style fixed point.
REQ-002 SHALL have port dac_clk_i, input, 1, the single clock.
REQ-003 SHALL have port dac_rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, one-cycle sweep start/restart pulse.
REQ-005 SHALL have port stop_i, input, 1, one-cycle abort pulse.
REQ-006 SHALL have port set_start_i, input, W, first step value.
REQ-007 SHALL have port set_stop_i, input, W, end step value.
REQ-008 SHALL have port set_inc_i, input, W, unsigned increment magnitude per update.
REQ-009 SHALL have port set_dwell_i, input, 32, cycles between updates.
REQ-010 SHALL have port set_mode_i, input, 2, sweep mode: 0 single, 1 repeat, 2 ping-pong, 3 reserved and treated as single.
REQ-011 SHALL have port step_o, output, W, current step; drives the channel's set_step_i.
REQ-012 SHALL have port step_vld_o, output, 1, one-cycle pulse whenever step_o is loaded.
REQ-013 SHALL have port busy_o, output, 1, high while sweeping.
REQ-014 SHALL have port done_o, output, 1, one-cycle pulse at single-sweep completion.
REQ-015 SHALL have port dir_o, output, 1, current direction: 1 up, 0 down.

Function
REQ-016 SHALL latch all set_* inputs on accepted start_i; changes while busy SHALL take effect only at the next start_i.
REQ-017 SHALL use states IDLE and RUN; transition IDLE->RUN on start_i; RUN->IDLE on stop_i or single-mode end.
REQ-018 On start_i in cycle n, SHALL output step_o=set_start, step_vld_o=1 and busy_o=1 in cycle n+1.
REQ-019 SHALL set dir = (set_stop >= set_start), unsigned compare, at start.
REQ-020 SHALL use effective dwell D = max(set_dwell,1); updates occur every D cycles after the previous step_vld_o.
REQ-021 On update, SHALL compute next = step ± inc in W+1 bits; if next passes or equals the target, or the sum/difference over/underflows, step_o SHALL be clamped to the target.
REQ-022 When step_o equals the target after an update, mode single SHALL pulse done_o in the same cycle, go IDLE and hold step_o.
REQ-023 When step_o equals the target after an update, mode repeat SHALL reload set_start after the next D cycles and keep the direction.
REQ-024 When step_o equals the target after an update, mode ping-pong SHALL invert dir_o and swap the target between set_stop and set_start.
REQ-025 If set_start == set_stop, SHALL behave as if the target was reached at the first output; single mode SHALL pulse done_o in cycle n+1.
REQ-026 With inc = 0, SHALL pulse step_vld_o each D cycles with an unchanged value and never complete.
REQ-027 start_i while busy SHALL restart the sweep per REQ-018.
REQ-028 stop_i SHALL clear busy_o next cycle, hold step_o, and emit no done_o.
REQ-029 If start_i and stop_i are asserted in the same cycle, stop SHALL win.
REQ-030 In IDLE, step_vld_o and done_o SHALL be 0 and step_o SHALL hold its value.

Reset
REQ-031 dac_rst_i SHALL force IDLE with step_o=0, step_vld_o=0, busy_o=0, done_o=0, dir_o=1 and the dwell counter at 0.
REQ-032 Reset mid-sweep SHALL take priority over start_i/stop_i in the same cycle.

Structure
REQ-033 Mode encodings (single/repeat/ping-pong) and state encodings SHALL live in the shared ASG package, reused by the register bank.
REQ-034 The dwell timer SHALL be one sub-module, red_pitaya_asg_sweep_tmr: load D, tick pulse each D cycles, synchronous clear.

Verification
REQ-035 Single mode: start=0x10000, stop=0x50000, inc=0x10000, dwell=3 -> step_o 0x10000,0x20000,...,0x50000 at 3-cycle spacing; done_o once with 0x50000; busy_o drops.
REQ-036 Overshoot clamp: start=0, stop=0x25000, inc=0x10000, dwell=1 -> 0, 0x10000, 0x20000, 0x25000, then done_o.
REQ-037 Ping-pong down-start: start=0x30000, stop=0x10000, inc=0x10000 -> 0x30000, 0x20000, 0x10000, 0x20000, 0x30000, ...; dir_o toggles at each end; no done_o.
REQ-038 Overflow: start=0x3FFF0000, stop=0x3FFFFFFF, inc=0x20000000 -> second step clamped to 0x3FFFFFFF, no wrap to a small value.
REQ-039 Controls: start_i+stop_i same cycle in IDLE -> stays IDLE; stop_i mid-sweep -> busy_o=0, step_o held, no done_o; dwell=0 -> updates every cycle.
REQ-040 Reset mid-sweep while start_i=1 -> next cycle step_o=0, busy_o=0, dir_o=1; repeat mode returns to set_start after the endpoint plus D cycles.
